// File: rtl/remote_comm_pkg.sv
// Shared definitions for the remote_comm robot link.
// Contents: the controller FSM state type, the robot response codes, and the default
// baud divider (clocks per UART bit at 50 MHz / 115200 baud).
package remote_comm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSendHi,
    StSendLo,
    StWaitResp
  } state_e;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  localparam int unsigned DEFAULT_BAUD_DIV = 434;

endpackage

// File: rtl/remote_comm_uart_tx.sv
// uart_tx: 8N1 byte serializer.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   trmt       - start a frame with tx_data; accepted only while idle
//   tx_data    - byte to send, sampled when trmt is accepted
//   TX         - registered serial output, idles high
//   tx_done    - one-cycle pulse after the stop bit has been on the line for BAUD_DIV clocks
module uart_tx
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int unsigned BaudW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BitW  = $clog2(10);

  logic             active_q;
  logic             tx_q;
  logic             done_q;
  logic [8:0]       shift_q;
  logic [BaudW-1:0] baud_q;
  logic [BitW-1:0]  bit_q;

  // bit_q: 0 = start bit on the line, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      shift_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (trmt) begin
          active_q <= 1'b1;
          tx_q     <= 1'b0;
          shift_q  <= {1'b1, tx_data};
          baud_q   <= '0;
          bit_q    <= '0;
        end
      end else if (baud_q == BaudW'(BAUD_DIV - 1)) begin
        baud_q <= '0;
        if (bit_q == BitW'(9)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
          tx_q     <= 1'b1;
        end else begin
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
          bit_q   <= bit_q + BitW'(1);
        end
      end else begin
        baud_q <= baud_q + BaudW'(1);
      end
    end
  end

  assign TX      = tx_q;
  assign tx_done = done_q;

endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command to the robot as two UART bytes (high byte first)
// and waits for a response byte. The receiver runs continuously, so unsolicited
// status bytes also update resp.
// Ports:
//   clk, rst_n - 50 MHz clock, synchronous active-low reset
//   cmd        - command word, captured when snd_cmd is accepted in idle
//   snd_cmd    - one-cycle send request (ignored while busy)
//   TX / RX    - UART line to / from the robot (RX is asynchronous)
//   cmd_snt    - pulse once both command bytes have gone out
//   resp       - last good response byte; resp_rdy pulses when it updates
//   busy       - controller is not idle
//   timeout    - pulse when no response arrives in time
// Optional feature: define REMOTE_COMM_TIMEOUT_EN to build the response timeout;
// otherwise timeout is tied low and the controller waits indefinitely.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = DEFAULT_BAUD_DIV,
  parameter int unsigned TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        busy,
  output logic        timeout
);

  localparam int unsigned BaudW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BitW  = $clog2(10);
  localparam int unsigned Half  = (BAUD_DIV > 1) ? BAUD_DIV / 2 : 1;

  state_e      state_q;
  logic [15:0] cmd_q;
  logic        cmd_snt_q;
  logic        busy_q;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  // The high byte goes straight from cmd so TX drops on the cycle after acceptance.
  assign trmt    = ((state_q == StIdle) && snd_cmd) || ((state_q == StSendHi) && tx_done);
  assign tx_data = (state_q == StIdle) ? cmd[15:8] : cmd_q[7:0];

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (trmt),
    .tx_data(tx_data),
    .TX     (TX),
    .tx_done(tx_done)
  );

  // Receiver
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  logic             rx_active_q;
  logic [BaudW-1:0] rx_baud_q;
  logic [BitW-1:0]  rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       resp_q;
  logic             resp_rdy_q;

  // rx_baud_q counts down to the next mid-bit sample; rx_bit_q 0 = start, 9 = stop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_active_q <= 1'b0;
      rx_baud_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      resp_q      <= 8'h00;
      resp_rdy_q  <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      resp_rdy_q <= 1'b0;
      if (!rx_active_q) begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_active_q <= 1'b1;
          rx_baud_q   <= BaudW'(Half - 1);
          rx_bit_q    <= '0;
        end
      end else if (rx_baud_q != '0) begin
        rx_baud_q <= rx_baud_q - BaudW'(1);
      end else begin
        rx_baud_q <= BaudW'(BAUD_DIV - 1);
        rx_bit_q  <= rx_bit_q + BitW'(1);
        if (rx_bit_q == '0) begin
          // Line back high at mid start bit: a glitch, not a frame.
          if (rx_s2_q) rx_active_q <= 1'b0;
        end else if (rx_bit_q == BitW'(9)) begin
          rx_active_q <= 1'b0;
          // A low stop bit is a framing error and the byte is dropped.
          if (rx_s2_q) begin
            resp_q     <= rx_shift_q;
            resp_rdy_q <= 1'b1;
          end
        end else begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
        end
      end
    end
  end

`ifdef REMOTE_COMM_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [ToW-1:0] to_cnt_q;
  logic           timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      cmd_snt_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef REMOTE_COMM_TIMEOUT_EN
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      cmd_snt_q <= 1'b0;
`ifdef REMOTE_COMM_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (snd_cmd) begin
            cmd_q   <= cmd;
            state_q <= StSendHi;
            busy_q  <= 1'b1;
          end
        end
        StSendHi: begin
          if (tx_done) state_q <= StSendLo;
        end
        StSendLo: begin
          if (tx_done) begin
            cmd_snt_q <= 1'b1;
            state_q   <= StWaitResp;
`ifdef REMOTE_COMM_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
          end
        end
        StWaitResp: begin
          if (resp_rdy_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
`ifdef REMOTE_COMM_TIMEOUT_EN
          // to_cnt_q holds cycles spent here minus one.
          else if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
            busy_q    <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_snt  = cmd_snt_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;
  assign busy     = busy_q;
`ifdef REMOTE_COMM_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule
